// File: rtl/hysteresis_level_qualifier.sv
// rtl/hysteresis_level_qualifier.sv - two-threshold comparator with minimum-hold debounce
//
// Purpose:
//   Turns a signed ADC sample stream into a clean binary level for the
//   downstream rising-edge pulse detector. A sample is "above" when
//   adc_q >= threshold_hi and "below" when adc_q <= threshold_lo. The level
//   switches only after M = max(min_hold, 1) consecutive qualifying samples.
//
// Ports:
//   clock         system clock, all logic on the rising edge
//   reset         synchronous, active-high reset
//   adc_in        signed ADC sample, one per clock (registered into adc_q)
//   threshold_hi  signed upper threshold
//   threshold_lo  signed lower threshold
//   min_hold      consecutive qualifying samples needed to switch (0 acts as 1)
//   enable        run enable; low forces the qualifier back to LOW
//   level_out     qualified level (1 in HIGH / QUAL_LOW)
//   config_error  registered flag, high while threshold_lo > threshold_hi
//   rise_count    number of LOW->HIGH transitions, wraps modulo 2^32

module hysteresis_level_qualifier #(
  parameter int DATA_WIDTH = 14,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] adc_in,
  input  logic [DATA_WIDTH-1:0] threshold_hi,
  input  logic [DATA_WIDTH-1:0] threshold_lo,
  input  logic [CNT_WIDTH-1:0]  min_hold,
  input  logic                  enable,
  output logic                  level_out,
  output logic                  config_error,
  output logic [31:0]           rise_count
);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_QUAL_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_QUAL_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   hold_q, hold_d;
  logic [DATA_WIDTH-1:0]  adc_q;
  logic                   cfg_err_q;
  logic                   level_q;
  logic [31:0]            rise_q;

  logic [CNT_WIDTH-1:0]   m_eff;
  logic [CNT_WIDTH-1:0]   hold_inc;
  logic                   m_is_one;
  logic                   hold_done;
  logic                   above;
  logic                   below;
  logic                   run;
  logic                   rise_evt;

  always_comb begin
    m_eff     = (min_hold == '0) ? CNT_ONE : min_hold;
    m_is_one  = (m_eff == CNT_ONE);
    // Saturating increment; a saturated count is >= any M, so a shrunken
    // min_hold still completes on the next qualifying sample.
    hold_inc  = (hold_q == '1) ? hold_q : hold_q + CNT_ONE;
    hold_done = (hold_inc >= m_eff);
    above     = ($signed(adc_q) >= $signed(threshold_hi));
    below     = ($signed(adc_q) <= $signed(threshold_lo));
    // The registered config flag gates the FSM exactly like enable=0.
    run       = enable && !cfg_err_q;

    state_d = state_q;
    hold_d  = hold_q;

    if (!run) begin
      state_d = S_LOW;
      hold_d  = '0;
    end else begin
      case (state_q)
        S_LOW: begin
          if (above) begin
            hold_d  = CNT_ONE;
            state_d = m_is_one ? S_HIGH : S_QUAL_HIGH;
          end else begin
            hold_d  = '0;
          end
        end
        S_QUAL_HIGH: begin
          if (!above) begin
            state_d = S_LOW;
            hold_d  = '0;
          end else if (hold_done) begin
            state_d = S_HIGH;
            hold_d  = '0;
          end else begin
            hold_d  = hold_inc;
          end
        end
        S_HIGH: begin
          if (below) begin
            hold_d  = CNT_ONE;
            state_d = m_is_one ? S_LOW : S_QUAL_LOW;
          end else begin
            hold_d  = '0;
          end
        end
        S_QUAL_LOW: begin
          if (!below) begin
            state_d = S_HIGH;
            hold_d  = '0;
          end else if (hold_done) begin
            state_d = S_LOW;
            hold_d  = '0;
          end else begin
            hold_d  = hold_inc;
          end
        end
        default: begin
          state_d = S_LOW;
          hold_d  = '0;
        end
      endcase
    end

    // Only genuine rises count; QUAL_LOW->HIGH is an aborted fall.
    rise_evt = (state_d == S_HIGH) &&
               ((state_q == S_LOW) || (state_q == S_QUAL_HIGH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_LOW;
      hold_q    <= '0;
      adc_q     <= '0;
      cfg_err_q <= 1'b0;
      level_q   <= 1'b0;
      rise_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      adc_q     <= adc_in;
      cfg_err_q <= ($signed(threshold_lo) > $signed(threshold_hi));
      level_q   <= (state_d == S_HIGH) || (state_d == S_QUAL_LOW);
      if (rise_evt) begin
        rise_q <= rise_q + 32'd1;
      end
    end
  end

  assign level_out    = level_q;
  assign config_error = cfg_err_q;
  assign rise_count   = rise_q;

endmodule
